// File: rtl/oh_iobufds_pkg.sv
// Shared definitions for the differential pad bank sequencer: state codes and
// the width helper for the turn/settle/idle counters.
package oh_iobufds_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RX_WAKE = 3'd1,
        ST_RX      = 3'd2,
        ST_TX_PREP = 3'd3,
        ST_TX      = 3'd4,
        ST_RX_TURN = 3'd5,
        ST_PARK    = 3'd6
    } state_e;

    // Wide enough to hold the largest of the three intervals.
    function automatic int cnt_width(input int turn_c, input int settle_c, input int idle_c);
        int m;
        m = turn_c;
        if (settle_c > m) m = settle_c;
        if (idle_c > m) m = idle_c;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/oh_iobufds_timer.sv
// Loadable down-counter with zero flag; times the turnaround and settle intervals.
module oh_iobufds_timer
    import oh_iobufds_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/oh_iobufds_seq.sv
// Direction and power sequencer for a bank of differential bidirectional pads.
// All lane controls are bank-wide and registered from the next-state decode.
module oh_iobufds_seq
    import oh_iobufds_pkg::*;
#(
    parameter int N             = 8,
    parameter int TURN_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int IDLE_CYCLES   = 64,
    parameter int USE_IBUFDIS   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_tx,
    input  logic         req_rx,
    input  logic [N-1:0] din,
    output logic         tx_ready,
    output logic [N-1:0] dout,
    output logic         rx_valid,
    output logic [2:0]   state,
    output logic [N-1:0] io_i,
    output logic [N-1:0] io_t,
    output logic [N-1:0] io_dcitermdisable,
    output logic [N-1:0] io_ibufdisable,
    input  logic [N-1:0] io_o
);

    localparam int CW = cnt_width(TURN_CYCLES, SETTLE_CYCLES, IDLE_CYCLES);
    localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic          IBUF_SEQ  = (USE_IBUFDIS != 0);

    state_e        r_state;
    state_e        w_next;
    logic [CW-1:0] r_idle;
    logic          w_idle;
    logic          w_timeout;
    logic          w_zero;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_rx_side;

    logic          r_tx_ready;
    logic          r_rx_valid;
    logic [N-1:0]  r_dout;
    logic [N-1:0]  r_io_i;
    logic [N-1:0]  r_io_t;
    logic [N-1:0]  r_dci;
    logic [N-1:0]  r_ibuf;

    assign w_idle    = !req_tx && !req_rx;
    assign w_timeout = w_idle && (r_idle == IDLE_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (req_tx)      w_next = ST_TX_PREP;
                else if (req_rx) w_next = ST_RX_WAKE;
            end
            ST_RX_WAKE: begin
                if (req_tx)      w_next = ST_TX_PREP;
                else if (w_zero) w_next = ST_RX;
            end
            ST_RX: begin
                if (req_tx)         w_next = ST_TX_PREP;
                else if (w_timeout) w_next = ST_OFF;
            end
            ST_TX_PREP: begin
                if (w_zero) w_next = req_tx ? ST_TX : ST_OFF;
            end
            ST_TX: begin
                if (!req_tx && req_rx) w_next = ST_RX_TURN;
                else if (w_timeout)    w_next = ST_PARK;
            end
            ST_RX_TURN: begin
                if (w_zero) w_next = ST_RX_WAKE;
            end
            ST_PARK: begin
                if (w_zero) w_next = ST_OFF;
            end
            default: w_next = ST_OFF;
        endcase
    end

    // The timer reloads on entry to any timed state, so it reads zero exactly
    // on the last cycle of that state's interval.
    assign w_load = (w_next != r_state) &&
                    ((w_next == ST_RX_WAKE) || (w_next == ST_TX_PREP) ||
                     (w_next == ST_RX_TURN) || (w_next == ST_PARK));
    assign w_load_val = (w_next == ST_RX_WAKE) ? SETTLE_LD : TURN_LD;

    oh_iobufds_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if ((w_next != r_state) || !w_idle) begin
            r_idle <= '0;
        end else if (r_idle < IDLE_LAST) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign w_rx_side = (w_next == ST_RX_WAKE) || (w_next == ST_RX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_OFF;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_dout     <= '0;
            r_io_i     <= '0;
            r_io_t     <= '1;
            r_dci      <= '1;
            r_ibuf     <= {N{IBUF_SEQ}};
        end else begin
            r_state    <= w_next;
            r_tx_ready <= (w_next == ST_TX);
            r_rx_valid <= (w_next == ST_RX);
            r_dout     <= (w_next == ST_RX) ? io_o : '0;
            r_io_i     <= ((r_state == ST_TX) && (w_next == ST_TX)) ? din : '0;
            r_io_t     <= {N{w_next != ST_TX}};
            r_dci      <= {N{!w_rx_side}};
            r_ibuf     <= {N{IBUF_SEQ && !w_rx_side}};
        end
    end

    assign state             = r_state;
    assign tx_ready          = r_tx_ready;
    assign rx_valid          = r_rx_valid;
    assign dout              = r_dout;
    assign io_i              = r_io_i;
    assign io_t              = r_io_t;
    assign io_dcitermdisable = r_dci;
    assign io_ibufdisable    = r_ibuf;

    a_no_drive_while_receiving: assert property (@(posedge clk) disable iff (reset)
        ((~r_io_t & ~r_dci) == '0) && (!IBUF_SEQ || ((~r_io_t & ~r_ibuf) == '0)));

    a_tx_after_full_turn: assert property (@(posedge clk) disable iff (reset)
        ((r_state == ST_TX) && ($past(r_state) != ST_TX)) |->
        (($past(r_state) == ST_TX_PREP) &&
         ($past(r_state, TURN_CYCLES) == ST_TX_PREP) &&
         ($past(r_state, TURN_CYCLES + 1) != ST_TX_PREP)));

endmodule

// File: tb/tb_oh_iobufds_seq.sv
// Bench for the pad bank sequencer: a state/duration model checked every cycle
// plus directed literal expectations along the main scenarios.
module tb_oh_iobufds_seq;

    localparam int N      = 8;
    localparam int TURN   = 4;
    localparam int SETTLE = 8;
    localparam int IDLE   = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_tx, req_rx;
    logic [N-1:0] din, io_o;

    logic         tx_ready, rx_valid;
    logic [N-1:0] dout, io_i, io_t, io_dci, io_ib;
    logic [2:0]   state;

    logic         tx_ready1, rx_valid1;
    logic [N-1:0] dout1, io_i1, io_t1, io_dci1, io_ib1;
    logic [2:0]   state1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    oh_iobufds_seq #(.N(N), .TURN_CYCLES(TURN), .SETTLE_CYCLES(SETTLE),
                     .IDLE_CYCLES(IDLE), .USE_IBUFDIS(1)) dut (
        .clk(clk), .reset(reset), .req_tx(req_tx), .req_rx(req_rx), .din(din),
        .tx_ready(tx_ready), .dout(dout), .rx_valid(rx_valid), .state(state),
        .io_i(io_i), .io_t(io_t), .io_dcitermdisable(io_dci),
        .io_ibufdisable(io_ib), .io_o(io_o));

    oh_iobufds_seq #(.N(N), .TURN_CYCLES(TURN), .SETTLE_CYCLES(SETTLE),
                     .IDLE_CYCLES(IDLE), .USE_IBUFDIS(0)) dut_noib (
        .clk(clk), .reset(reset), .req_tx(req_tx), .req_rx(req_rx), .din(din),
        .tx_ready(tx_ready1), .dout(dout1), .rx_valid(rx_valid1), .state(state1),
        .io_i(io_i1), .io_t(io_t1), .io_dcitermdisable(io_dci1),
        .io_ibufdisable(io_ib1), .io_o(io_o));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: each state is held for a fixed number of cycles (age counts
    // cycles spent there) and idle time is counted in consecutive quiet edges.
    int           m_st, m_age, m_idle, m_ns;
    logic [N-1:0] m_dout, m_ioi;

    function automatic int model_next(input int st, input int age, input int idl,
                                      input logic tx, input logic rx);
        bit quiet;
        quiet = !tx && !rx;
        case (st)
            0: return tx ? 3 : (rx ? 1 : 0);
            1: return tx ? 3 : ((age == SETTLE) ? 2 : 1);
            2: return tx ? 3 : ((quiet && idl + 1 == IDLE) ? 0 : 2);
            3: return (age == TURN) ? (tx ? 4 : 0) : 3;
            4: return (!tx && rx) ? 5 : ((quiet && idl + 1 == IDLE) ? 6 : 4);
            5: return (age == TURN) ? 1 : 5;
            6: return (age == TURN) ? 0 : 6;
            default: return 0;
        endcase
    endfunction

    always_comb m_ns = model_next(m_st, m_age, m_idle, req_tx, req_rx);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st <= 0; m_age <= 0; m_idle <= 0; m_dout <= '0; m_ioi <= '0;
        end else begin
            m_ioi  <= (m_st == 4 && m_ns == 4) ? din : '0;
            m_dout <= (m_ns == 2) ? io_o : '0;
            m_idle <= (m_ns == m_st && !req_tx && !req_rx) ? m_idle + 1 : 0;
            m_age  <= (m_ns == m_st) ? m_age + 1 : 1;
            m_st   <= m_ns;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_t, e_dci;
        e_t   = (m_st == 4) ? '0 : '1;
        e_dci = (m_st == 1 || m_st == 2) ? '0 : '1;
        chk("m_state",    32'(state),    32'(m_st));
        chk("m_io_t",     32'(io_t),     32'(e_t));
        chk("m_dci",      32'(io_dci),   32'(e_dci));
        chk("m_ibuf",     32'(io_ib),    32'(e_dci));
        chk("m_io_i",     32'(io_i),     32'(m_ioi));
        chk("m_dout",     32'(dout),     32'(m_dout));
        chk("m_rx_valid", 32'(rx_valid), 32'(m_st == 2));
        chk("m_tx_ready", 32'(tx_ready), 32'(m_st == 4));
        chk("m1_state",   32'(state1),   32'(m_st));
        chk("m1_io_t",    32'(io_t1),    32'(e_t));
        chk("m1_dci",     32'(io_dci1),  32'(e_dci));
        chk("m1_ibuf",    32'(io_ib1),   32'h0);
        chk("m1_dout",    32'(dout1),    32'(m_dout));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_tx = 1'b0; req_rx = 1'b0; din = '0; io_o = '0;
        tick(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_io_t", 32'(io_t), 32'hFF);
        chk("rst_dci", 32'(io_dci), 32'hFF);
        chk("rst_ibuf", 32'(io_ib), 32'hFF);
        chk("rst_ibuf_noib", 32'(io_ib1), 32'h00);
        chk("rst_outs", {29'd0, rx_valid, tx_ready, |{io_i, dout}}, 32'd0);
        reset = 1'b0;

        // 1: wake into receive
        req_rx = 1'b1; io_o = 8'hA5;
        tick(1);
        chk("t1_wake_state", 32'(state), 32'd1);
        chk("t1_dci_fall", 32'(io_dci), 32'h00);
        chk("t1_ibuf_fall", 32'(io_ib), 32'h00);
        chk("t1_rxv_early", 32'(rx_valid), 32'd0);
        tick(7);
        chk("t1_rxv_c8", 32'(rx_valid), 32'd0);
        tick(1);
        chk("t1_rxv_c9", 32'(rx_valid), 32'd1);
        chk("t1_dout_a5", 32'(dout), 32'hA5);
        io_o = 8'h5A;
        tick(1);
        chk("t1_dout_5a", 32'(dout), 32'h5A);

        // 2: receive -> transmit
        req_tx = 1'b1; din = 8'h3C;
        tick(1);
        chk("t2_prep_state", 32'(state), 32'd3);
        chk("t2_rxv_drop", 32'(rx_valid), 32'd0);
        chk("t2_dout_drop", 32'(dout), 32'd0);
        tick(3);
        chk("t2_io_t_c4", 32'(io_t), 32'hFF);
        tick(1);
        chk("t2_io_t_low", 32'(io_t), 32'h00);
        chk("t2_tx_ready", 32'(tx_ready), 32'd1);
        chk("t2_io_i_entry", 32'(io_i), 32'h00);
        tick(1);
        chk("t2_io_i_3c", 32'(io_i), 32'h3C);
        din = 8'hC3;
        tick(1);
        chk("t2_io_i_c3", 32'(io_i), 32'hC3);

        // 3: transmit -> receive via turnaround and wake
        req_tx = 1'b0;
        tick(1);
        chk("t3_turn_state", 32'(state), 32'd5);
        chk("t3_turn_io_i", 32'(io_i), 32'h00);
        tick(3);
        chk("t3_turn_c4", 32'(state), 32'd5);
        tick(1);
        chk("t3_wake_state", 32'(state), 32'd1);
        tick(7);
        chk("t3_wake_c8", 32'(rx_valid), 32'd0);
        tick(1);
        chk("t3_rxv", 32'(rx_valid), 32'd1);

        // 4: idle timeout out of RX, then both requests, then park
        req_rx = 1'b0;
        tick(IDLE - 1);
        chk("t4_rx_hold", 32'(state), 32'd2);
        tick(1);
        chk("t4_rx_off", 32'(state), 32'd0);
        req_tx = 1'b1; req_rx = 1'b1;
        tick(1 + TURN);
        chk("t4_tx_wins", 32'(state), 32'd4);
        req_tx = 1'b0; req_rx = 1'b0;
        tick(IDLE - 1);
        chk("t4_tx_hold", 32'(state), 32'd4);
        tick(1);
        chk("t4_park", 32'(state), 32'd6);
        chk("t4_park_io_t", 32'(io_t), 32'hFF);
        tick(3);
        chk("t4_park_c4", 32'(state), 32'd6);
        tick(1);
        chk("t4_off", 32'(state), 32'd0);
        chk("t4_off_ctl", {io_t, io_dci, io_ib}, 24'hFFFFFF);

        // 5: asynchronous reset mid-TX and mid-wake
        req_tx = 1'b1;
        tick(1 + TURN + 1);
        chk("t5_tx2", 32'(state), 32'd4);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_tx_state", 32'(state), 32'd0);
        chk("t5_rst_tx_io_t", 32'(io_t), 32'hFF);
        chk("t5_rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("t5_rst_tx_noib", 32'(io_ib1), 32'h00);
        tick(1);
        reset = 1'b0; req_tx = 1'b0; req_rx = 1'b1;
        tick(3);
        chk("t5_mid_wake", 32'(state), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_wake_dci", 32'(io_dci), 32'hFF);
        chk("t5_rst_wake_ibuf", 32'(io_ib), 32'hFF);
        chk("t5_rst_wake_noib", 32'(io_ib1), 32'h00);
        tick(1);
        reset = 1'b0; req_rx = 1'b0;
        tick(3);
        chk("t5_final_off", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
